// File: rtl/mfp_ahb_uart_tx_pkg.sv
// mfp_ahb_uart_tx_pkg: register offsets, status bit positions and serializer states
package mfp_ahb_uart_tx_pkg;
    localparam logic [1:0] TX_DATA_OFF   = 2'd0;
    localparam logic [1:0] TX_STATUS_OFF = 2'd1;
    localparam logic [1:0] TX_LEVEL_OFF  = 2'd2;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 4;
    localparam int ST_OVF   = 5;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/mfp_ahb_uart_tx_if.sv
// mfp_ahb_uart_tx_if: AHB-Lite responder signal bundle
interface mfp_ahb_uart_tx_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        SI_Endian;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    modport slave (input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, SI_Endian,
                   output HRDATA, HREADYOUT, HRESP);
    modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, SI_Endian,
                    input HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/mfp_uart_transmitter.sv
// mfp_uart_transmitter: 8N1 serializer, LSB first, one byte accepted per frame in IDLE
module mfp_uart_transmitter
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       tx
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] TOP = TW'(DIV - 1);
    tx_state_t     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    assign byte_ready = state_q == S_IDLE;
    assign busy       = state_q != S_IDLE;
    assign tx         = tx_q;
    // Frame FSM; STOP leaves one clock early so the IDLE load cycle completes the stop bit and frames chain gaplessly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (byte_valid) begin
                    state_q <= S_START;
                    shift_q <= byte_data;
                    timer_q <= TOP;
                    tx_q    <= 1'b0;
                end
                S_START: if (timer_q == '0) begin
                    state_q <= S_DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    idx_q   <= '0;
                    timer_q <= TOP;
                end else timer_q <= timer_q - 1'b1;
                S_DATA: if (timer_q == '0) begin
                    timer_q <= TOP;
                    if (idx_q == 3'd7) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end else timer_q <= timer_q - 1'b1;
                S_STOP: if (timer_q == TW'(1)) state_q <= S_IDLE;
                        else timer_q <= timer_q - 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx: AHB-Lite UART transmitter with byte FIFO, status and level registers
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200,
    parameter int FIFO_AW  = 4
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    mfp_ahb_uart_tx_if.slave   ahb,
    output logic               UART_TX
);
    logic             sel_q, write_q, ovf_q;
    logic [1:0]       addr_q;
    logic [2:0]       size_q;
    logic [FIFO_AW:0] wr_q, rd_q, level;
    logic [7:0]       mem [2**FIFO_AW];
    logic             full, empty, push_req, push, pop, tx_ready, tx_busy, unused_ok;
    logic [7:0]       wbyte;
    logic [31:0]      status;
    assign level    = wr_q - rd_q;
    assign empty    = wr_q == rd_q;
    assign full     = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign push_req = sel_q && write_q && addr_q == TX_DATA_OFF;
    assign push     = push_req && !full;
    assign pop      = tx_ready && !empty;
    assign wbyte    = (ahb.SI_Endian && size_q == HSIZE_BYTE) ? ahb.HWDATA[31:24] : ahb.HWDATA[7:0];
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign unused_ok = &{1'b0, ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[23:8]};
    // Status word assembled from live FIFO/serializer state
    always_comb begin
        status           = '0;
        status[ST_OVF]   = ovf_q;
        status[ST_BUSY]  = tx_busy;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
    end
    assign ahb.HRDATA = (!sel_q || write_q) ? '0 :
                        addr_q == TX_STATUS_OFF ? status :
                        addr_q == TX_LEVEL_OFF  ? 32'(level) : '0;
    // Address-phase capture, FIFO pointers and sticky overflow (a write that hits a full FIFO wins over a clearing read)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sel_q   <= ahb.HSEL && ahb.HTRANS[1];
            write_q <= ahb.HWRITE;
            addr_q  <= ahb.HADDR[3:2];
            size_q  <= ahb.HSIZE;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push_req && full) ovf_q <= 1'b1;
            else if (sel_q && !write_q && addr_q == TX_STATUS_OFF) ovf_q <= 1'b0;
        end
    end
    // FIFO storage needs no reset; occupancy is defined by the pointers
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_q[FIFO_AW-1:0]] <= wbyte;
    end
    mfp_uart_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clock      (HCLK),
        .reset_n    (HRESETn),
        .byte_data  (mem[rd_q[FIFO_AW-1:0]]),
        .byte_valid (!empty),
        .byte_ready (tx_ready),
        .busy       (tx_busy),
        .tx         (UART_TX)
    );
endmodule
